sa_add_sequencer: RTL and testbench
===================================

# sa_add_sequencer

Controller that sequences the shared 4x4 systolic-array-plus-adder datapath (`SystolicArray_ADD`) for two requesters, e.g. the score path and the context path of the attention block. It arbitrates round-robin and runs one fixed-latency operation at a time: accumulator flush, multiply window, optional add window, completion pulse. It drives the array's control pins and the operand-mux select, and returns a per-requester done strobe at the cycle the results are valid.

## Interface
- `MUL_LAT`, 10: cycles from flush release until both product matrices are valid; must be ≥1.
- `ADD_LAT`, 1: cycles the adder needs once `AddFlag` is raised; must be ≥1.
- `CNT_W`, 6: width of the phase counter; must hold max(`MUL_LAT`, `ADD_LAT`).

Ports:
- `clk` in 1: single clock. All logic is rising-edge.
- `_reset` in 1: reset is synchronous and active-high.
- `req` in 2: `req[i]` high requests one operation for requester i.
- `req_add` in 2: per requester, add the C matrices after multiply.
- `req_int` in 2: per requester, integer-operand addition (drives `IntFlag`).
- `gnt` out 2: one-hot owner of the datapath. The owner holds its operands stable while granted.
- `sel` out 1: operand/result mux select, equal to the index of the granted requester.
- `done` out 2: one-cycle pulse to the owner. Datapath results are valid in that cycle.
- `busy` out 1: high while any operation is in flight.
- `sa_reset_n` out 1: drives the array `_reset` (active-low).
- `sa_flush_acc_n` out 1: drives the array `_flush_acc` (active-low).
- `sa_add_flag` out 1: drives `AddFlag`.
- `sa_int_flag` out 1: drives `IntFlag`.
- `perf_busy` out 32: count of busy cycles (see Configuration).
- `perf_ops` out 16: count of completed operations (see Configuration).

## Operation
- All outputs are registered.
- The FSM has five states: IDLE, FLUSH, MUL, ADD, DONE.
- **IDLE**
  - If `req == 0`, stay in IDLE.
  - Otherwise, grant one requester. If both request, grant the one not served last. The last-served pointer resets to 1, so requester 0 wins first.
  - Latch the winner's `req_add` and `req_int`. Go to FLUSH.
- **FLUSH**: one cycle with `sa_flush_acc_n=0`. Then go to MUL and load the counter with `MUL_LAT-1`.
- **MUL**: decrement the counter each cycle. At 0:
  - go to ADD if latched add=1, loading the counter with `ADD_LAT-1`;
  - otherwise go to DONE.
- **ADD**: `sa_add_flag=1` and `sa_int_flag=` latched int. Decrement; at 0, go to DONE.
- **DONE**
  - `done[owner]=1` for one cycle; `sa_add_flag` and `sa_int_flag` stay as in ADD.
  - Next state is always IDLE, where `gnt` clears and the pointer updates to the owner.
- `gnt` and `sel` are constant from FLUSH through DONE.
- `busy=1` in FLUSH, MUL, ADD and DONE.
- `req`, `req_add` and `req_int` are ignored outside IDLE. Dropping `req` mid-operation does not abort it.
- `sa_reset_n` is 0 during reset and rises on the first cycle after `_reset` deasserts.

## Timing
- Reset values:
  - FSM: IDLE.
  - `gnt=0`, `sel=0`, `done=0`, `busy=0`.
  - `sa_reset_n=0`, `sa_flush_acc_n=1`, `sa_add_flag=0`, `sa_int_flag=0`.
  - Counters 0, pointer 1.
- With `req` sampled high at edge k:
  - FLUSH at k+1;
  - MUL during k+2 … k+1+`MUL_LAT`;
  - ADD during the following `ADD_LAT` cycles (add only);
  - DONE at k+2+`MUL_LAT`+`ADD_LAT` with add, or k+2+`MUL_LAT` without.
- Minimum spacing between operations is one IDLE cycle after DONE.
- If `_reset` is asserted mid-operation, all outputs take their reset values on the next edge. No `done` is issued and the request is lost. The requester must re-request.
- If `req` arrives in the DONE cycle, it is sampled in the following IDLE cycle.

## Configuration
- `SA_SEQ_PERF_EN` defined:
  - `perf_busy` increments on every cycle with `busy=1`.
  - `perf_ops` increments on every DONE cycle.
  - Both wrap and both reset to 0.
- `SA_SEQ_PERF_EN` undefined: both counters are omitted and the outputs are tied to 0.

## Test plan
All scenarios use `MUL_LAT=10`, `ADD_LAT=1`.
- Reset, then `req=01`, `req_add=0` at edge 0:
  - `sa_flush_acc_n=0` at cycle 1;
  - `done=01` at cycle 12;
  - `sa_add_flag` never high.
- `req=10`, `req_add=10`, `req_int=10`:
  - `sa_add_flag=1` and `sa_int_flag=1` on cycles 12–13;
  - `done=10` at cycle 13;
  - `sel=1` on cycles 1–13.
- `req=11` held continuously:
  - grants alternate 01, 10, 01;
  - each `done` is 12 cycles after its FLUSH-1 edge;
  - one IDLE cycle between operations.
- `req=01` with `_reset` pulsed at cycle 5:
  - at cycle 6, `gnt=0`, `busy=0`, `sa_reset_n=0`;
  - no `done`;
  - a new request completes normally.
- `req[0]` dropped at cycle 3: the operation still completes with `done=01` at cycle 12.
- With `SA_SEQ_PERF_EN` defined, after three no-add ops: `perf_ops=3`, `perf_busy=36`. Without the macro, both read 0.

Source files
------------

// File: rtl/sa_add_sequencer.sv
// Round-robin sequencer for the shared systolic-array + adder datapath: flush, multiply, optional add, done.
// Optional perf counters are built when SA_SEQ_PERF_EN is defined; otherwise perf_busy/perf_ops read 0.
module sa_add_sequencer #(
  parameter int MUL_LAT = 10,
  parameter int ADD_LAT = 1,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        _reset,
  input  logic [1:0]  req,
  input  logic [1:0]  req_add,
  input  logic [1:0]  req_int,
  output logic [1:0]  gnt,
  output logic        sel,
  output logic [1:0]  done,
  output logic        busy,
  output logic        sa_reset_n,
  output logic        sa_flush_acc_n,
  output logic        sa_add_flag,
  output logic        sa_int_flag,
  output logic [31:0] perf_busy,
  output logic [15:0] perf_ops
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_MUL,
    S_ADD,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic               add_q, add_d;
  logic               int_q, int_d;

  logic [1:0]         gnt_q, gnt_d;
  logic               sel_q, sel_d;
  logic [1:0]         done_q, done_d;
  logic               busy_q, busy_d;
  logic               sa_reset_n_q;
  logic               flush_n_q, flush_n_d;
  logic               add_flag_q, add_flag_d;
  logic               int_flag_q, int_flag_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    add_d   = add_q;
    int_d   = int_q;

    unique case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          // With both requesting, the one not served last wins.
          owner_d = (req == 2'b11) ? ~last_q : req[1];
          add_d   = req_add[owner_d];
          int_d   = req_int[owner_d];
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        state_d = S_MUL;
        cnt_d   = CNT_W'(MUL_LAT - 1);
      end
      S_MUL: begin
        if (cnt_q == '0) begin
          if (add_q) begin
            state_d = S_ADD;
            cnt_d   = CNT_W'(ADD_LAT - 1);
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ADD: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        last_d  = owner_q;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered pins line up with the state they describe.
    busy_d     = (state_d != S_IDLE);
    gnt_d      = busy_d ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
    sel_d      = owner_d;
    done_d     = (state_d == S_DONE) ? gnt_d : 2'b00;
    flush_n_d  = (state_d != S_FLUSH);
    add_flag_d = (state_d == S_ADD) || ((state_d == S_DONE) && add_d);
    int_flag_d = add_flag_d && int_d;
  end

  always_ff @(posedge clk) begin
    if (_reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      add_q        <= 1'b0;
      int_q        <= 1'b0;
      gnt_q        <= 2'b00;
      sel_q        <= 1'b0;
      done_q       <= 2'b00;
      busy_q       <= 1'b0;
      sa_reset_n_q <= 1'b0;
      flush_n_q    <= 1'b1;
      add_flag_q   <= 1'b0;
      int_flag_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      add_q        <= add_d;
      int_q        <= int_d;
      gnt_q        <= gnt_d;
      sel_q        <= sel_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      sa_reset_n_q <= 1'b1;
      flush_n_q    <= flush_n_d;
      add_flag_q   <= add_flag_d;
      int_flag_q   <= int_flag_d;
    end
  end

  assign gnt            = gnt_q;
  assign sel            = sel_q;
  assign done           = done_q;
  assign busy           = busy_q;
  assign sa_reset_n     = sa_reset_n_q;
  assign sa_flush_acc_n = flush_n_q;
  assign sa_add_flag    = add_flag_q;
  assign sa_int_flag    = int_flag_q;

`ifdef SA_SEQ_PERF_EN
  logic [31:0] perf_busy_q;
  logic [15:0] perf_ops_q;

  always_ff @(posedge clk) begin
    if (_reset) begin
      perf_busy_q <= '0;
      perf_ops_q  <= '0;
    end else begin
      perf_busy_q <= perf_busy_q + 32'(busy_q);
      perf_ops_q  <= perf_ops_q + 16'(done_q != 2'b00);
    end
  end

  assign perf_busy = perf_busy_q;
  assign perf_ops  = perf_ops_q;
`else
  assign perf_busy = '0;
  assign perf_ops  = '0;
`endif

endmodule

// File: tb/tb_sa_add_sequencer.sv
// Randomized + directed bench for sa_add_sequencer against a timeline model of each operation.
// Cycle n below names the outputs visible between edge n-1 and edge n; they are sampled on the falling edge.
module tb_sa_add_sequencer;

  localparam int MUL_LAT = 10;
  localparam int ADD_LAT = 1;
  localparam int CNT_W   = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0, req_add = '0, req_int = '0;
  logic [1:0]  gnt, done;
  logic        sel, busy, sa_reset_n, sa_flush_acc_n, sa_add_flag, sa_int_flag;
  logic [31:0] perf_busy;
  logic [15:0] perf_ops;

  always #5 clk = ~clk;

  sa_add_sequencer #(.MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    ._reset        (rst),
    .req           (req),
    .req_add       (req_add),
    .req_int       (req_int),
    .gnt           (gnt),
    .sel           (sel),
    .done          (done),
    .busy          (busy),
    .sa_reset_n    (sa_reset_n),
    .sa_flush_acc_n(sa_flush_acc_n),
    .sa_add_flag   (sa_add_flag),
    .sa_int_flag   (sa_int_flag),
    .perf_busy     (perf_busy),
    .perf_ops      (perf_ops)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit checks_on = 1'b0;
  int done_cyc  = -1;
  logic [1:0] flush_gnts[$];

  // Reference model: the current operation as a timeline (start edge, done cycle), plus arbitration pointer.
  bit op_valid = 1'b0;
  int op_k, op_done;
  bit op_owner, op_add, op_int;
  bit last_srv = 1'b1;
  bit rst_prev = 1'b1;
  int mbusy = 0;
  int mops  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_cycle();
    bit         active;
    bit         add_win;
    logic [1:0] g;
    active  = op_valid && (cyc >= op_k + 1) && (cyc <= op_done);
    g       = active ? (op_owner ? 2'b10 : 2'b01) : 2'b00;
    add_win = active && op_add && (cyc >= op_k + 2 + MUL_LAT);
    check("gnt", gnt, g);
    check("busy", busy, active);
    check("done", done, (active && cyc == op_done) ? g : 2'b00);
    check("flush_n", sa_flush_acc_n, !(active && cyc == op_k + 1));
    check("add_flag", sa_add_flag, add_win);
    check("int_flag", sa_int_flag, add_win && op_int);
    check("sa_reset_n", sa_reset_n, !rst_prev);
    if (active) check("sel", sel, op_owner);
`ifdef SA_SEQ_PERF_EN
    check("perf_busy", perf_busy, mbusy);
    check("perf_ops", perf_ops, mops & 'hFFFF);
`else
    check("perf_busy", perf_busy, 0);
    check("perf_ops", perf_ops, 0);
`endif
    if (done !== 2'b00) done_cyc = cyc;
    if (sa_flush_acc_n === 1'b0) flush_gnts.push_back(gnt);
    if (active) mbusy++;
    if (active && cyc == op_done) mops++;
  endtask

  task automatic model_edge(input logic [1:0] r, input logic [1:0] ra, input logic [1:0] ri, input logic rs);
    if (rs) begin
      op_valid = 1'b0;
      last_srv = 1'b1;
      mbusy    = 0;
      mops     = 0;
      rst_prev = 1'b1;
    end else begin
      rst_prev = 1'b0;
      if (op_valid && cyc == op_done) last_srv = op_owner;
      if (!(op_valid && cyc <= op_done) && r != 2'b00) begin
        if (r == 2'b11) op_owner = !last_srv;
        else            op_owner = (r == 2'b10);
        op_add   = ra[op_owner];
        op_int   = ri[op_owner];
        op_k     = cyc;
        op_done  = cyc + 2 + MUL_LAT + (op_add ? ADD_LAT : 0);
        op_valid = 1'b1;
      end
    end
  endtask

  task automatic tick(input logic [1:0] r, input logic [1:0] ra, input logic [1:0] ri, input logic rs);
    if (checks_on) check_cycle();
    req     = r;
    req_add = ra;
    req_int = ri;
    rst     = rs;
    @(posedge clk);
    model_edge(r, ra, ri, rs);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(2'b00, 2'b00, 2'b00, 1'b0);
  endtask

  int         s;
  logic [1:0] rr, ra, ri;

  initial begin
    @(negedge clk);
    tick(2'b00, 2'b00, 2'b00, 1'b1);
    checks_on = 1'b1;
    repeat (2) tick(2'b00, 2'b00, 2'b00, 1'b1);
    idle(1);

    // Single multiply-only op from requester 0.
    s = cyc; done_cyc = -1;
    tick(2'b01, 2'b00, 2'b00, 1'b0);
    idle(14);
    check("s1_done_latency", done_cyc - s, 12);

    // Integer add op from requester 1.
    s = cyc; done_cyc = -1;
    tick(2'b10, 2'b10, 2'b10, 1'b0);
    idle(15);
    check("s2_done_latency", done_cyc - s, 13);

    // Both requesting continuously: grants alternate starting with 0.
    flush_gnts.delete();
    repeat (40) tick(2'b11, 2'b00, 2'b00, 1'b0);
    idle(14);
    check("s3_n_ops", flush_gnts.size(), 4);
    if (flush_gnts.size() >= 3) begin
      check("s3_grant0", flush_gnts[0], 2'b01);
      check("s3_grant1", flush_gnts[1], 2'b10);
      check("s3_grant2", flush_gnts[2], 2'b01);
    end

    // Reset mid-operation: no done, then a fresh request completes.
    s = cyc;
    repeat (5) tick(2'b01, 2'b00, 2'b00, 1'b0);
    done_cyc = -1;
    tick(2'b00, 2'b00, 2'b00, 1'b1);
    idle(15);
    check("s4_no_done", done_cyc, -1);
    s = cyc; done_cyc = -1;
    tick(2'b01, 2'b00, 2'b00, 1'b0);
    idle(14);
    check("s4_reissue_latency", done_cyc - s, 12);

    // Request dropped mid-operation still completes.
    s = cyc; done_cyc = -1;
    repeat (3) tick(2'b01, 2'b00, 2'b00, 1'b0);
    idle(12);
    check("s5_done_latency", done_cyc - s, 12);

    // Three multiply-only ops after reset for the perf counters.
    tick(2'b00, 2'b00, 2'b00, 1'b1);
    repeat (3) begin
      rr = 2'($urandom_range(1, 3));
      tick(rr, 2'b00, 2'($urandom), 1'b0);
      idle(12);
    end
    idle(2);
`ifdef SA_SEQ_PERF_EN
    check("perf_busy_3ops", perf_busy, 36);
    check("perf_ops_3ops", perf_ops, 3);
`else
    check("perf_busy_off", perf_busy, 0);
    check("perf_ops_off", perf_ops, 0);
`endif

    // Random traffic with occasional resets.
    repeat (800) begin
      rr = 2'($urandom);
      ra = 2'($urandom);
      ri = 2'($urandom);
      if ($urandom_range(0, 2) == 0) rr = 2'b00;
      tick(rr, ra, ri, $urandom_range(0, 199) == 0);
    end
    idle(16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
